// File: rtl/pixel_fetch_sequencer_pkg.sv
// Shared types for the pixel fetch sequencer: FSM state encoding and a width helper.
package pixel_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_WAIT,
        S_DRAIN
    } state_t;

    // Minimum width that can index v entries; never returns less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pixel_fetch_sequencer_if.sv
// Arbiter channel (req/rdy) and pixel output stream (valid/ready) of the fetch sequencer.
interface pixel_fetch_sequencer_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    logic                     data_req;
    logic [ADDRESS_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     data_rdy;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output data_req, data_addr, out_valid, out_data, out_last,
        input  data_in, data_rdy, out_ready
    );

    modport slave (
        input  data_req, data_addr, out_valid, out_data, out_last,
        output data_in, data_rdy, out_ready
    );
endinterface

// File: rtl/pixel_fetch_sequencer_fifo.sv
// Synchronous FIFO with flush; pointers carry a wrap bit to separate full from empty.
module pixel_fetch_sequencer_fifo
    import pixel_fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/pixel_fetch_sequencer.sv
// Fetches NUM_PIXELS words from BASE_ADDR through one arbiter channel into a stream FIFO.
// Optional watchdog on a stalled request: define PIXEL_FETCH_TIMEOUT_EN.
module pixel_fetch_sequencer
    import pixel_fetch_sequencer_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter int                       DATA_WIDTH     = 8,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                       NUM_PIXELS     = 60,
    parameter int                       FIFO_DEPTH     = 4,
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    pixel_fetch_sequencer_if.master bus_io
);
`ifdef PIXEL_FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int            CW      = clog2(NUM_PIXELS + 1);
    localparam int            TW      = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] NUM_C   = CW'(NUM_PIXELS);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     flush, push, pop, last_pop;
    logic                     fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]      head;

    assign push     = (state_q == S_REQ) && bus_io.data_rdy;
    assign pop      = bus_io.out_valid && bus_io.out_ready;
    assign last_pop = pop && bus_io.out_last;

    pixel_fetch_sequencer_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .push_i  (push),
        .din_i   ({cnt_q == NUM_C - CW'(1), bus_io.data_in}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus_io.data_req  = (state_q == S_REQ);
    assign bus_io.data_addr = addr_q;
    assign bus_io.out_valid = !fifo_empty;
    assign bus_io.out_data  = head[DATA_WIDTH-1:0];
    // The last flag travels with the word; also require the fetch count to be complete.
    assign bus_io.out_last  = !fifo_empty && head[DATA_WIDTH] && (cnt_q == NUM_C);
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done_q;
    assign err_o            = TMO_EN ? err_q : 1'b0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;
        flush   = 1'b0;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                addr_d  = BASE_ADDR;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_REQ;
            end
            S_REQ: if (bus_io.data_rdy) begin
                addr_d  = addr_q + ADDRESS_WIDTH'(1);
                cnt_d   = cnt_q + CW'(1);
                state_d = S_RELEASE;
            end else if (TMO_EN) begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == TMO_LIM) begin
                    flush   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            // The final word can already be popped here when the consumer is fast.
            S_RELEASE: begin
                if (last_pop) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == NUM_C) state_d = S_DRAIN;
                else if (fifo_full)          state_d = S_WAIT;
                else                         state_d = S_REQ;
            end
            S_WAIT: if (!fifo_full) state_d = S_REQ;
            S_DRAIN: if (last_pop) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Directed bench: frame of 6 words from 8'hFE (address wrap), backpressure, reset and restart cases.
module tb_pixel_fetch_sequencer;
    localparam int NUM = 6;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic busy, done, err;
    logic rdy_m = 1'b0, oready = 1'b0;
    logic [7:0] din_m = 8'h00;
    bit   stall = 1'b0;

    always #5 clk = ~clk;

    pixel_fetch_sequencer_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();
    assign bus.data_rdy  = rdy_m;
    assign bus.data_in   = din_m;
    assign bus.out_ready = oready;

    pixel_fetch_sequencer #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (8),
        .BASE_ADDR     (8'hFE),
        .NUM_PIXELS    (NUM),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err),
        .bus_io (bus.master)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } vec_t;
    vec_t tbl [NUM];

    int errors = 0, checks = 0;
    int gap_err = 0, seq_err = 0;
    bit hs_prev = 1'b0, lp_prev = 1'b0;
    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];
    logic       q_last [$];

    // Arbiter + memory: rdy one cycle after req, data = addr ^ 8'hA5, rdy drops with req.
    always @(posedge clk) begin
        if (!stall && bus.data_req && !rdy_m) begin
            rdy_m <= 1'b1;
            din_m <= bus.data_addr ^ 8'hA5;
        end else begin
            rdy_m <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus.data_req && bus.data_rdy) q_addr.push_back(bus.data_addr);
        if (hs_prev && bus.data_req) gap_err <= gap_err + 1;
        hs_prev <= bus.data_req && bus.data_rdy;
        if (bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
        end
        if (done != lp_prev) seq_err <= seq_err + 1;
        lp_prev <= bus.out_valid && bus.out_ready && bus.out_last;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic check_frame(input int ba, input int bd, input string tag);
        chk({tag, "_addr_count"}, 32'(q_addr.size() - ba), NUM);
        chk({tag, "_word_count"}, 32'(q_data.size() - bd), NUM);
        for (int i = 0; i < NUM; i++) begin
            if (ba + i < q_addr.size()) chk({tag, "_addr"}, q_addr[ba+i], tbl[i].addr);
            if (bd + i < q_data.size()) begin
                chk({tag, "_data"}, q_data[bd+i], tbl[i].data);
                chk({tag, "_last"}, q_last[bd+i], tbl[i].last);
            end
        end
    endtask

    initial begin
        int ba, bd, hsn, rc;
        bit ok;
        tbl[0] = '{8'hFE, 8'h5B, 1'b0};
        tbl[1] = '{8'hFF, 8'h5A, 1'b0};
        tbl[2] = '{8'h00, 8'hA5, 1'b0};
        tbl[3] = '{8'h01, 8'hA4, 1'b0};
        tbl[4] = '{8'h02, 8'hA7, 1'b0};
        tbl[5] = '{8'h03, 8'hA6, 1'b1};

        #1 rst_n = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", bus.data_req, 0);
        chk("rst_addr", bus.data_addr, 0);
        chk("rst_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame A: consumer stalled, FIFO fills, then release
        ba = q_addr.size(); bd = q_data.size();
        pulse_start();
        repeat (40) @(negedge clk);
        chk("A_stall_handshakes", 32'(q_addr.size() - ba), 4);
        chk("A_stall_req", bus.data_req, 0);
        chk("A_stall_valid", bus.out_valid, 1);
        chk("A_stall_head", bus.out_data, 8'h5B);
        chk("A_stall_last", bus.out_last, 0);
        chk("A_stall_busy", busy, 1);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("A_ignored_start", 32'(q_addr.size() - ba), 4);
        oready = 1'b1;
        wait_done(200, ok);
        chk("A_done_seen", ok, 1);
        chk("A_done_busy", busy, 0);
        check_frame(ba, bd, "A");

        // Frame B: start issued in the done cycle
        ba = q_addr.size(); bd = q_data.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("B_busy_after_start", busy, 1);
        chk("B_done_pulse_width", done, 0);
        wait_done(200, ok);
        chk("B_done_seen", ok, 1);
        check_frame(ba, bd, "B");

        // Reset during the request of the 3rd word
        oready = 1'b0;
        ba = q_addr.size();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (q_addr.size() - ba == 2 && bus.data_req) ok = 1'b1;
        end
        chk("C_reached_third_req", ok, 1);
        chk("C_valid_before_rst", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("C_rst_req", bus.data_req, 0);
        chk("C_rst_busy", busy, 0);
        chk("C_rst_valid", bus.out_valid, 0);
        chk("C_rst_addr", bus.data_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hsn = q_addr.size();
        repeat (10) @(negedge clk);
        chk("C_idle_handshakes", 32'(q_addr.size() - hsn), 0);
        chk("C_idle_busy", busy, 0);
        chk("C_idle_req", bus.data_req, 0);

        oready = 1'b1;
        ba = q_addr.size(); bd = q_data.size();
        pulse_start();
        wait_done(200, ok);
        chk("D_done_seen", ok, 1);
        check_frame(ba, bd, "D");

`ifdef PIXEL_FETCH_TIMEOUT_EN
        stall = 1'b1;
        pulse_start();
        rc = bus.data_req ? 1 : 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.data_req) rc++;
        end
        chk("T_req_cycles", rc, 16);
        chk("T_err", err, 1);
        chk("T_busy", busy, 0);
        chk("T_valid", bus.out_valid, 0);
        stall = 1'b0;
        ba = q_addr.size(); bd = q_data.size();
        pulse_start();
        chk("T_err_cleared", err, 0);
        wait_done(200, ok);
        chk("T_done_seen", ok, 1);
        check_frame(ba, bd, "T");
`endif

        repeat (3) @(negedge clk);
        chk("req_gap_violations", gap_err, 0);
        chk("done_sequence_errors", seq_err, 0);
        chk("final_err", err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
